// File: rtl/shared_buf_pkg.sv
// Shared definitions for the shared-buffer arbiter.
//   state_e : buffer occupancy state (EMPTY=0, FULL=1)
//   XFER_W  : width of the completed-handshake counter
//   src_w() : width of a requester index, never less than 1 bit
package shared_buf_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int XFER_W = 8;

  function automatic int src_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_buf_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
// Ports:
//   req  [N_REQ-1:0] : candidate requesters
//   ptr  [SRC_W-1:0] : index holding highest priority this cycle
//   en               : allow a grant at all
//   gnt  [N_REQ-1:0] : one-hot grant (all-zero if en=0 or no request)
//   idx  [SRC_W-1:0] : index of the granted requester (0 when no grant)
module rr_arbiter
  import shared_buf_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int SRC_W = src_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [SRC_W-1:0] idx
);

  logic found;
  int   cand;

  // Scan from ptr upward, wrapping; first valid requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    if (en) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = (int'(ptr) + k) % N_REQ;
        if (!found && req[cand]) begin
          gnt[cand] = 1'b1;
          idx       = SRC_W'(cand);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shared_buf_arbiter.sv
// shared_buf_arbiter: one WIDTH-bit buffer register shared by N_REQ requesters.
// A round-robin arbiter loads a requester's word into the buffer; the buffer
// is drained by a single consumer with a valid/ready handshake.
// Optional feature macro: BUF_TIMEOUT_EN -- discard a word held FULL for
// TIMEOUT cycles without out_ready (pulses drop). Undefined: word held forever.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid [N_REQ-1:0]      : per-requester word valid
//   req_data  [N_REQ*WIDTH-1:0]: packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready [N_REQ-1:0]      : one-hot combinational grant
//   out_valid                  : buffer holds a word
//   out_data  [WIDTH-1:0]      : buffered word
//   out_src   [SRC_W-1:0]      : requester that supplied out_data
//   out_ready                  : consumer accepts out_data
//   xfer_cnt  [7:0]            : completed consumer handshakes, wrapping
//   drop                       : one-cycle pulse when a buffered word is discarded
module shared_buf_arbiter
  import shared_buf_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int WIDTH   = 4,
  parameter  int TIMEOUT = 15,
  localparam int SRC_W   = src_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_ready,
  output logic [XFER_W-1:0]      xfer_cnt,
  output logic                   drop
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic [SRC_W-1:0]  src_q,   src_d;
  logic [SRC_W-1:0]  ptr_q,   ptr_d;
  logic [XFER_W-1:0] xfer_q,  xfer_d;

  logic [N_REQ-1:0]  gnt;
  logic [SRC_W-1:0]  win;
  logic              can_load;
  logic              grant;
  logic              timeout_hit;

  // A load is possible when empty, or when the current word drains this cycle.
  // Reset suppresses all grants.
  assign can_load = !rst && ((state_q == EMPTY) || out_ready);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (can_load),
    .gnt (gnt),
    .idx (win)
  );

  assign grant     = |gnt;
  assign req_ready = gnt;

`ifdef BUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_q, wait_d;

  // Discard only while the consumer is stalled, so a late out_ready in the
  // final cycle still completes a normal handshake.
  assign timeout_hit = !rst && (state_q == FULL) && !out_ready &&
                       (wait_q == TW'(TIMEOUT));

  always_comb begin
    wait_d = wait_q;
    if (grant || out_ready || timeout_hit || (state_q == EMPTY))
      wait_d = '0;
    else
      wait_d = wait_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    xfer_d  = xfer_q;
    if ((state_q == FULL) && out_ready)
      xfer_d = xfer_q + XFER_W'(1);
    if (grant) begin
      data_d  = req_data[int'(win)*WIDTH +: WIDTH];
      src_d   = win;
      ptr_d   = (int'(win) == N_REQ - 1) ? '0 : win + SRC_W'(1);
      state_d = FULL;
    end else if ((state_q == FULL) && (out_ready || timeout_hit)) begin
      // Drained or discarded with nothing to reload; data/src keep last value.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      xfer_q  <= xfer_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign xfer_cnt  = xfer_q;
  assign drop      = timeout_hit;

endmodule

// File: tb/tb_shared_buf_arbiter.sv
// Directed self-checking bench for shared_buf_arbiter (N_REQ=4, WIDTH=4, TIMEOUT=3).
module tb_shared_buf_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic [7:0]  xfer_cnt;
  logic        drop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shared_buf_arbiter #(.N_REQ(4), .WIDTH(4), .TIMEOUT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt),
    .drop      (drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bp;
    // Reset with every requester valid
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    out_ready = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    tick();
    tick();
    chk("rst_req_ready2", req_ready, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_out_src", out_src, 2'd0);
    chk("rst_xfer", xfer_cnt, 8'd0);
    chk("rst_drop", drop, 1'b0);
    rst       = 1'b0;
    req_valid = 4'b0000;
    tick();

    // Single requester 2 with data A
    req_valid = 4'b0100;
    req_data  = 16'h0A00;
    out_ready = 1'b1;
    #1;
    chk("single_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 4'hA);
    chk("single_src", out_src, 2'd2);
    chk("single_xfer0", xfer_cnt, 8'd0);
    tick();
    chk("single_xfer1", xfer_cnt, 8'd1);
    chk("single_empty", out_valid, 1'b0);

    // Move ptr back to 0 by granting requester 3
    req_valid = 4'b1000;
    req_data  = 16'h8765;
    #1;
    chk("rr_pre_grant", req_ready, 4'b1000);
    tick();

    // Round robin with all requesters valid, out_ready held
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", req_ready, 4'b0001 << (k % 4));
      tick();
      chk("rr_src", out_src, k % 4);
      chk("rr_data", out_data, 5 + (k % 4));
    end
    chk("rr_xfer", xfer_cnt, 8'd6);

    // Backpressure after loading 5 from requester 1
    req_valid = 4'b0010;
    req_data  = 16'h0050;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    tick();
    chk("bp_load_data", out_data, 4'h5);
    chk("bp_load_src", out_src, 2'd1);
    chk("bp_xfer", xfer_cnt, 8'd7);
    out_ready = 1'b0;
    req_valid = 4'b1101;
    req_data  = 16'h9302;
`ifdef BUF_TIMEOUT_EN
    bp = 3;
`else
    bp = 10;
`endif
    for (int i = 0; i < bp; i++) begin
      #1;
      chk("bp_ready_zero", req_ready, 4'b0000);
      chk("bp_hold_data", out_data, 4'h5);
      chk("bp_hold_valid", out_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_grant", req_ready, 4'b0100);
    tick();
    chk("bp_release_xfer", xfer_cnt, 8'd8);
    chk("bp_release_data", out_data, 4'h3);
    chk("bp_release_src", out_src, 2'd2);

    // Fairness: requester 3 continuous, requester 1 joins at cycle 5
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("fair_r3", req_ready, 4'b1000);
      tick();
    end
    req_valid = 4'b1010;
    #1;
    chk("fair_r1_first", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("fair_r3_again", req_ready, 4'b1000);
    tick();

    // Drain with no grant: data and src hold
    req_valid = 4'b0000;
    tick();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_data_hold", out_data, 4'h9);
    chk("drain_src_hold", out_src, 2'd3);
    chk("drain_xfer", xfer_cnt, 8'd16);

    // xfer_cnt wrap: one load then a handshake every cycle
    req_valid = 4'b1111;
    for (int i = 0; i < 241; i++) tick();
    chk("xfer_wrap_zero", xfer_cnt, 8'd0);
    for (int i = 0; i < 16; i++) tick();
    chk("xfer_wrap_16", xfer_cnt, 8'd16);
    req_valid = 4'b0000;
    tick();
    chk("pre_to_xfer", xfer_cnt, 8'd17);
    chk("pre_to_empty", out_valid, 1'b0);

    // Hold FULL with out_ready low
    req_valid = 4'b0001;
    req_data  = 16'h000C;
    tick();
    req_valid = 4'b0000;
    out_ready = 1'b0;
`ifdef BUF_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      chk("to_no_drop", drop, 1'b0);
      chk("to_valid", out_valid, 1'b1);
      tick();
    end
    chk("to_drop", drop, 1'b1);
    chk("to_drop_xfer", xfer_cnt, 8'd17);
    tick();
    chk("to_after_valid", out_valid, 1'b0);
    chk("to_after_drop", drop, 1'b0);
    chk("to_after_xfer", xfer_cnt, 8'd17);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("hold_valid", out_valid, 1'b1);
    chk("hold_data", out_data, 4'hC);
    chk("hold_drop", drop, 1'b0);
    chk("hold_xfer", xfer_cnt, 8'd17);
`endif

    // Reset mid-operation
    out_ready = 1'b0;
    req_valid = 4'b0001;
    req_data  = 16'h000E;
    tick();
    rst       = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("midrst_ready", req_ready, 4'b0000);
    tick();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 4'h0);
    chk("midrst_xfer", xfer_cnt, 8'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
